// File: rtl/shifter_a.sv
// ---------------------------------------------------------------------------
// shifter_a : word-wide tapped delay line
//
// DEPTH stages of WIDTH bits each. Words enter at stage 0 on every enabled
// clock edge and leave at stage DEPTH-1. Every stage is visible on the
// parallel tap array 'out', and the last stage is also driven on 'so'.
//
// Optional build macro: SHIFTER_A_VALID_EN
//   When defined, a 1-bit valid flag travels with every word (input vi,
//   outputs vld[0:DEPTH-1] and so_vld). When undefined, those ports and
//   flops are absent. The data path is identical in both builds.
// ---------------------------------------------------------------------------
module shifter_a #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shn,
   input  logic [WIDTH-1:0] si,
   output logic [WIDTH-1:0] so,
   output logic [WIDTH-1:0] out [0:DEPTH-1]
`ifdef SHIFTER_A_VALID_EN
   ,
   input  logic             vi,
   output logic             vld [0:DEPTH-1],
   output logic             so_vld
`endif
);

   // Storage for the delay line; stage[0] is the newest word
   logic [WIDTH-1:0] stage [0:DEPTH-1];

   // Linear shift on enabled edges; reset clears everything without a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage[k] <= '0;
         end
      end else if (shn) begin
         stage[0] <= si;
         for (int k = 1; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   // Taps are the flops themselves, so there is no extra output latency
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         out[k] = stage[k];
      end
      so = stage[DEPTH-1];
   end

`ifdef SHIFTER_A_VALID_EN
   // Valid flags, one per stage, marching in lockstep with the data words
   logic vldq [0:DEPTH-1];

   // Same enable and reset as the data so a flag never drifts from its word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            vldq[k] <= 1'b0;
         end
      end else if (shn) begin
         vldq[0] <= vi;
         for (int k = 1; k < DEPTH; k++) begin
            vldq[k] <= vldq[k-1];
         end
      end
   end

   // Expose the flags directly, last stage also as the serial valid
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         vld[k] = vldq[k];
      end
      so_vld = vldq[DEPTH-1];
   end
`endif

endmodule

// File: tb/tb_shifter_a.sv
// ---------------------------------------------------------------------------
// tb_shifter_a : self-checking bench for shifter_a
//
// The reference model keeps the list of words accepted since the last reset
// (newest last). Tap k is expected to be the word accepted k shifting edges
// ago, or zero if fewer than k+1 words have been accepted.
// ---------------------------------------------------------------------------
module tb_shifter_a;

   localparam int WIDTH = 4;
   localparam int DEPTH = 9;

   logic             clk;
   logic             rst_n;
   logic             shn;
   logic [WIDTH-1:0] si;
   logic [WIDTH-1:0] so;
   logic [WIDTH-1:0] out [0:DEPTH-1];
`ifdef SHIFTER_A_VALID_EN
   logic             vi;
   logic             vld [0:DEPTH-1];
   logic             so_vld;
`endif

   int checks = 0;
   int errors = 0;

   // Words accepted since reset, oldest first
   logic [WIDTH-1:0] hist [$];

   shifter_a #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .shn   (shn),
      .si    (si),
      .so    (so),
      .out   (out)
`ifdef SHIFTER_A_VALID_EN
      ,
      .vi    (vi),
      .vld   (vld),
      .so_vld(so_vld)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Expected value of tap k according to the accepted-word history
   function automatic logic [WIDTH-1:0] tapModel(input int k);
      if (k < hist.size()) return hist[hist.size()-1-k];
      return '0;
   endfunction

   // Compare every tap and the serial output against the model
   task automatic checkAll(input string phase);
      for (int k = 0; k < DEPTH; k++) begin
         checkOutput($sformatf("%s out[%0d]", phase, k), 32'(out[k]), 32'(tapModel(k)));
      end
      checkOutput($sformatf("%s so", phase), 32'(so), 32'(tapModel(DEPTH-1)));
   endtask

   // Drive one edge from a negedge, update the model, check at the next negedge
   task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] d,
                                input string phase);
      shn = s;
      si  = d;
      @(posedge clk);
      if (rst_n && s) begin
         hist.push_back(d);
         if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      @(negedge clk);
      checkAll(phase);
   endtask

   // Asynchronous reset between edges: zero immediately, no shift while low
   task automatic pulseReset(input string phase);
      #2;
      rst_n = 1'b0;
      #1;
      hist.delete();
      checkAll({phase, " async"});
      shn = 1'b1;
      si  = 4'($urandom_range(1, 15));
      @(posedge clk);
      @(negedge clk);
      checkAll({phase, " held"});
      rst_n = 1'b1;
   endtask

   initial begin
      logic [WIDTH-1:0] seq [4];
      rst_n = 1'b0;
      shn   = 1'b0;
      si    = '0;
`ifdef SHIFTER_A_VALID_EN
      vi    = 1'b0;
`endif
      #1;
      checkAll("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Hold with a nonzero input: nothing may enter
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b1010, "hold");

      // Fill with a constant word
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'b0110, "fill");

      // Reset while full of nonzero data
      pulseReset("rstfill");

      // Ordering of four distinct words, then drain toward so
      seq = '{4'b0110, 4'b1011, 4'b0001, 4'b1111};
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq[i], "order");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0000, "drain");

      // Pause mid-stream, then resume
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i + 3), "prefill");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'(15 - i), "pause");
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i + 9), "resume");

      // Full of 1111, reset, then a single 0001
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'b1111, "ones");
      pulseReset("rstones");
      applyStimulus(1'b1, 4'b0001, "refill");

      // Random traffic with occasional mid-stream resets
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) pulseReset("rand");
         else applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
